rs_dispatch: RTL
================

RS_DISPATCH -- requirements
Module: rs_dispatch

Interface
REQ-001 SHALL have parameter NUM_ENT, default 4, giving the number of reservation-station entries (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, giving the operand width.
REQ-003 SHALL have parameter TAG_W, default 3, giving the ROB-index width.
REQ-004 SHALL have port clk1  input  1  the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  synchronous clear of all entries and of the output slot.
REQ-007 SHALL have ports alloc_valid/alloc_func/alloc_rd/alloc_rob  input  1/4/4/TAG_W  issue request: opcode, destination register, ROB index.
REQ-008 SHALL have ports alloc_v1, alloc_v2  input  DATA_W  operand values; alloc_p1, alloc_p2  input  1  operand pending; alloc_q1, alloc_q2  input  TAG_W  producing ROB tag when pending.
REQ-009 SHALL have port alloc_ready  output  1  at least one free entry exists.
REQ-010 SHALL have ports cdb_valid/cdb_rob/cdb_data  input  1/TAG_W/DATA_W  common-data-bus result broadcast.
REQ-011 SHALL have ports exec_b/rs_index/func/rd/rob_ind/rs1_data/rs2_data  output  1/3/4/4/TAG_W/DATA_W/DATA_W  dispatch to the execution stage.
REQ-012 SHALL have port exec_ready  input  1  execution stage accepts the presented operation this cycle.

Function
REQ-013 SHALL accept an allocation when alloc_valid=1 and alloc_ready=1, writing the lowest-index free entry; alloc_valid with alloc_ready=0 SHALL be ignored without state change.
REQ-014 SHALL derive alloc_ready only from the entry state at the start of the cycle; an entry freed in the same cycle SHALL NOT raise alloc_ready until the next cycle.
REQ-015 SHALL, when cdb_valid=1, capture cdb_data into every valid entry operand whose pending flag is set and whose tag equals cdb_rob, clearing that pending flag.
REQ-016 SHALL apply CDB forwarding to the operands being allocated in the same cycle: a pending operand whose tag matches cdb_rob SHALL be stored as ready with cdb_data.
REQ-017 SHALL treat an entry as ready when it is valid and both pending flags are clear at the start of the cycle.
REQ-018 SHALL hold a one-deep registered output slot; the slot SHALL be loadable in a cycle when exec_b=0, or when exec_b=1 and exec_ready=1.
REQ-019 SHALL, when the slot is loadable and a ready entry exists, load the slot from the lowest-index ready entry, set exec_b=1 and free that entry in the same edge.
REQ-020 SHALL hold all dispatch outputs stable while exec_b=1 and exec_ready=0.
REQ-021 SHALL clear exec_b when exec_ready=1 and no ready entry exists.
REQ-022 SHALL give a minimum latency of two rising edges from an allocation with both operands ready to exec_b=1, and of two edges from the CDB edge that resolves the last operand to exec_b=1.
REQ-023 SHALL drive rs_index with the freed entry number, zero-extended to 3 bits.
REQ-024 SHALL pass func, rd and rob_ind unmodified; operand values SHALL never be altered.
REQ-025 SHALL, on flush=1, invalidate all entries and clear exec_b in that edge, ignoring any simultaneous allocation, CDB write or dispatch.

Reset
REQ-026 SHALL, on rst=1 at a clock edge, invalidate all entries and clear all pending flags; rst SHALL take priority over flush.
REQ-027 SHALL, after reset, drive exec_b=0, rs_index=0, func=0, rd=0, rob_ind=0, rs1_data=0, rs2_data=0 and alloc_ready=1.

Structure
REQ-028 SHALL take DATA_W/TAG_W defaults and opcode constants (ADD=0000, SUB=0001, MUL=0010, DIV=0011, LD=0100, ST=0101) from shared package tomasulo_pkg, together with the entry record typedef (valid, func, rd, rob, v1, p1, q1, v2, p2, q2).
REQ-029 SHALL implement free-entry and ready-entry selection with one sub-module, rs_prio_enc (lowest-index-first priority encoder, found flag plus index), instantiated twice.

Verification
REQ-030 Directed test: reset, then alloc ADD rd=5 rob=2 v1=3 v2=4 with both operands ready -> exec_b=1 two edges later with rs_index=0, rs1_data=3, rs2_data=4, rob_ind=2, rd=5.
REQ-031 Directed test: alloc SUB with p1=1, q1=6, v2=9; cdb rob=6 data=20 three cycles later -> exec_b=1 two edges after the CDB edge with rs1_data=20, rs2_data=9.
REQ-032 Directed test: alloc with p2=1, q2=4 while cdb_valid rob=4 data=7 in the same cycle -> entry ready immediately, rs2_data=7 at dispatch.
REQ-033 Directed test: NUM_ENT=4, four allocs with pending operands -> alloc_ready=0; a fifth alloc is ignored; resolving entry 2 -> dispatch with rs_index=2, then alloc_ready=1 one cycle after the free.
REQ-034 Directed test: two ready entries with exec_ready=0 for 3 cycles -> outputs stable on entry 0; exec_ready=1 -> entry 1 is presented next cycle and exec_b stays 1.
REQ-035 Directed test: flush while exec_b=1 and three entries valid -> next cycle exec_b=0 and alloc_ready=1; a later CDB broadcast causes no dispatch.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: default widths, opcode encodings and the
// reservation-station entry record.
package tomasulo_pkg;

  localparam int RS_DATA_W = 8;
  localparam int RS_TAG_W  = 3;

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_MUL = 4'b0010,
    OP_DIV = 4'b0011,
    OP_LD  = 4'b0100,
    OP_ST  = 4'b0101
  } rs_op_e;

  // p1/p2 set means the operand is still waiting for ROB tag q1/q2
  typedef struct packed {
    logic                 valid;
    logic [3:0]           func;
    logic [3:0]           rd;
    logic [RS_TAG_W-1:0]  rob;
    logic [RS_DATA_W-1:0] v1;
    logic                 p1;
    logic [RS_TAG_W-1:0]  q1;
    logic [RS_DATA_W-1:0] v2;
    logic                 p2;
    logic [RS_TAG_W-1:0]  q2;
  } rs_entry_t;

endpackage

// File: rtl/rs_dispatch_if.sv
// Issue, CDB and dispatch signals of one reservation station.
// master drives requests/broadcasts, slave is the reservation station.
interface rs_dispatch_if #(
  parameter int DATA_W = tomasulo_pkg::RS_DATA_W,
  parameter int TAG_W  = tomasulo_pkg::RS_TAG_W
);

  logic              alloc_valid;
  logic [3:0]        alloc_func;
  logic [3:0]        alloc_rd;
  logic [TAG_W-1:0]  alloc_rob;
  logic [DATA_W-1:0] alloc_v1;
  logic [DATA_W-1:0] alloc_v2;
  logic              alloc_p1;
  logic              alloc_p2;
  logic [TAG_W-1:0]  alloc_q1;
  logic [TAG_W-1:0]  alloc_q2;
  logic              alloc_ready;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_rob;
  logic [DATA_W-1:0] cdb_data;

  logic              exec_b;
  logic [2:0]        rs_index;
  logic [3:0]        func;
  logic [3:0]        rd;
  logic [TAG_W-1:0]  rob_ind;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  logic              exec_ready;

  modport master (
    output alloc_valid, alloc_func, alloc_rd, alloc_rob,
    output alloc_v1, alloc_v2, alloc_p1, alloc_p2, alloc_q1, alloc_q2,
    output cdb_valid, cdb_rob, cdb_data, exec_ready,
    input  alloc_ready, exec_b, rs_index, func, rd, rob_ind, rs1_data, rs2_data
  );

  modport slave (
    input  alloc_valid, alloc_func, alloc_rd, alloc_rob,
    input  alloc_v1, alloc_v2, alloc_p1, alloc_p2, alloc_q1, alloc_q2,
    input  cdb_valid, cdb_rob, cdb_data, exec_ready,
    output alloc_ready, exec_b, rs_index, func, rd, rob_ind, rs1_data, rs2_data
  );

endinterface

// File: rtl/rs_prio_enc.sv
// Lowest-index-first priority encoder with a found flag.
module rs_prio_enc #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    found_o = |req_i;
    idx_o   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rs_dispatch.sv
// Reservation station: allocates issued ops, wakes operands from the CDB and
// dispatches the lowest-index ready entry through a one-deep output slot.
module rs_dispatch
  import tomasulo_pkg::*;
#(
  parameter int NUM_ENT = 4,
  parameter int DATA_W  = RS_DATA_W,
  parameter int TAG_W   = RS_TAG_W
) (
  input  logic         clk1,
  input  logic         rst,
  input  logic         flush,
  rs_dispatch_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_ENT);

  rs_entry_t          ent_q [NUM_ENT];
  rs_entry_t          ent_d [NUM_ENT];
  rs_entry_t          new_ent;

  logic [NUM_ENT-1:0] free_vec;
  logic [NUM_ENT-1:0] rdy_vec;
  logic               free_found;
  logic               rdy_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   rdy_idx;
  logic               load_ok;
  logic               dispatch;

  logic               exec_b_q,   exec_b_d;
  logic [2:0]         rs_index_q, rs_index_d;
  logic [3:0]         func_q,     func_d;
  logic [3:0]         rd_q,       rd_d;
  logic [TAG_W-1:0]   rob_q,      rob_d;
  logic [DATA_W-1:0]  rs1_q,      rs1_d;
  logic [DATA_W-1:0]  rs2_q,      rs2_d;

  // Captures a broadcast result into any pending operand waiting on its tag.
  function automatic rs_entry_t wake(input rs_entry_t e, input logic cv,
                                     input logic [TAG_W-1:0] tag,
                                     input logic [DATA_W-1:0] data);
    rs_entry_t r;
    r = e;
    if (cv && e.valid && e.p1 && (e.q1 == tag)) begin
      r.v1 = data;
      r.p1 = 1'b0;
    end
    if (cv && e.valid && e.p2 && (e.q2 == tag)) begin
      r.v2 = data;
      r.p2 = 1'b0;
    end
    return r;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) begin
      free_vec[i] = ~ent_q[i].valid;
      rdy_vec[i]  = ent_q[i].valid & ~ent_q[i].p1 & ~ent_q[i].p2;
    end
  end

  rs_prio_enc #(.N(NUM_ENT), .IDX_W(IDX_W)) u_free_enc (
    .req_i   (free_vec),
    .found_o (free_found),
    .idx_o   (free_idx)
  );

  rs_prio_enc #(.N(NUM_ENT), .IDX_W(IDX_W)) u_rdy_enc (
    .req_i   (rdy_vec),
    .found_o (rdy_found),
    .idx_o   (rdy_idx)
  );

  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.func  = bus.alloc_func;
    new_ent.rd    = bus.alloc_rd;
    new_ent.rob   = bus.alloc_rob;
    new_ent.v1    = bus.alloc_v1;
    new_ent.p1    = bus.alloc_p1;
    new_ent.q1    = bus.alloc_q1;
    new_ent.v2    = bus.alloc_v2;
    new_ent.p2    = bus.alloc_p2;
    new_ent.q2    = bus.alloc_q2;
  end

  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) begin
      ent_d[i] = wake(ent_q[i], bus.cdb_valid, bus.cdb_rob, bus.cdb_data);
    end

    exec_b_d   = exec_b_q;
    rs_index_d = rs_index_q;
    func_d     = func_q;
    rd_d       = rd_q;
    rob_d      = rob_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;

    // Slot accepts a new op when empty or when the current one is consumed.
    load_ok  = ~exec_b_q | bus.exec_ready;
    dispatch = load_ok & rdy_found;

    if (dispatch) begin
      ent_d[rdy_idx].valid = 1'b0;
      exec_b_d   = 1'b1;
      rs_index_d = 3'(rdy_idx);
      func_d     = ent_q[rdy_idx].func;
      rd_d       = ent_q[rdy_idx].rd;
      rob_d      = ent_q[rdy_idx].rob;
      rs1_d      = ent_q[rdy_idx].v1;
      rs2_d      = ent_q[rdy_idx].v2;
    end else if (bus.exec_ready) begin
      exec_b_d = 1'b0;
    end

    // Free and ready entries are disjoint, so the write never hits the dispatched slot.
    if (bus.alloc_valid && free_found) begin
      ent_d[free_idx] = wake(new_ent, bus.cdb_valid, bus.cdb_rob, bus.cdb_data);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        ent_q[i].valid <= 1'b0;
        ent_q[i].p1    <= 1'b0;
        ent_q[i].p2    <= 1'b0;
      end
      exec_b_q   <= 1'b0;
      rs_index_q <= '0;
      func_q     <= '0;
      rd_q       <= '0;
      rob_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        ent_q[i].valid <= 1'b0;
      end
      exec_b_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_ENT; i++) begin
        ent_q[i] <= ent_d[i];
      end
      exec_b_q   <= exec_b_d;
      rs_index_q <= rs_index_d;
      func_q     <= func_d;
      rd_q       <= rd_d;
      rob_q      <= rob_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
    end
  end

  assign bus.alloc_ready = free_found;
  assign bus.exec_b      = exec_b_q;
  assign bus.rs_index    = rs_index_q;
  assign bus.func        = func_q;
  assign bus.rd          = rd_q;
  assign bus.rob_ind     = rob_q;
  assign bus.rs1_data    = rs1_q;
  assign bus.rs2_data    = rs2_q;

endmodule
